delay_line_ctrl: RTL and testbench
==================================

Name: delay_line_ctrl

Overview:
- Sample-counted, run-time-programmable delay for a signed stream.
- Sequences a circular sample buffer with write/read pointers plus a fill/flush FSM. This replaces fixed-parameter cycle delays wherever the delay must change at run time (e.g. channel alignment).
- Sits between a producer with valid-only strobes and a consumer that cannot apply backpressure.

Parameters:
- WIDTH, 16, sample width in bits (signed)
- MAX_DELAY, 64, largest programmable delay in samples, ≥1; buffer depth = MAX_DELAY
- DW, $clog2(MAX_DELAY+1), width of delay fields (localparam)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cfg_delay  in  DW  requested delay in samples, sampled on cfg_load
- cfg_load  in  1  single-cycle pulse: apply cfg_delay, restart line
- cfg_busy  out  1  high while FLUSH or FILL
- in_valid  in  1  in_data is a new sample this cycle
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_data  in  WIDTH  signed input sample
- out_valid  out  1  registered; pulses one cycle after each accepted sample
- out_data  out  WIDTH  signed, registered delayed sample
- fill_count  out  DW  accepted samples since last restart, saturating at active delay

Behaviour:
- Reset (async, rst=1):
  - State IDLE; active delay D=0; pointers and fill_count = 0.
  - out_valid=0, out_data=0, cfg_busy=0, in_ready=1.
  - Buffer contents are don't-care; zero-fill logic masks them.
- FSM states and transitions:
  - IDLE: D=0 pass-through. Each accepted sample gives out_data=in_data, out_valid=1 on the next cycle.
  - cfg_load in any state → FLUSH. Latch D=cfg_delay, clamped to MAX_DELAY.
  - FLUSH: lasts exactly 1 cycle. in_ready=0, wr_ptr=0, fill_count=0, out_valid=0. Next state is FILL if D>0, else IDLE.
  - FILL: accepted samples are written to the buffer. out_valid pulses with out_data=0 (zero fill) and fill_count increments. On the D-th accepted sample, move to RUN.
  - RUN: each accepted sample is written at wr_ptr. The sample read is the one accepted D samples earlier. out_valid pulses.
- Latency: 1 clk from acceptance to out_valid in every state. The delay is counted in samples, not cycles; idle cycles do not advance the line.
- Pointers:
  - wr_ptr wraps from MAX_DELAY-1 to 0 (non-power-of-two safe).
  - rd_ptr = (wr_ptr - D) mod MAX_DELAY, computed without underflow.
  - D=MAX_DELAY: read is before write at the same address, giving the old entry.
- Simultaneous events:
  - cfg_load with an accepted in_valid in the same cycle: the sample still produces out_valid next cycle using the old D. The new D is latched, then FLUSH follows.
  - cfg_load during FLUSH restarts FLUSH with the new value.
- in_valid while in_ready=0: the sample is dropped, and the producer must tolerate this. in_ready is low only in FLUSH.
- Reset mid-operation: immediate return to reset values, with no output pulse.

Optional Feature:
- Macro: DELAY_LINE_CFG_CHECK_EN.
- Defined:
  - Adds output port cfg_err (1 bit, sticky). It sets when cfg_load sees cfg_delay>MAX_DELAY and clears on rst or on a legal cfg_load.
  - Also adds a simulation assertion that in_valid is never high while in_ready=0.
- Undefined: no cfg_err port; clamping still applies silently.

Decomposition:
- Shared package delay_pkg:
  - state enum typedef (IDLE, FLUSH, FILL, RUN)
  - delay-width helper function
  - the zero-fill constant
- One sub-module: delay_ram, a simple dual-port, read-before-write, MAX_DELAY×WIDTH registered-read buffer, inferred as block or distributed RAM.
- The FSM, pointers and output register live in the top level.

Test Plan:
- Reset release, no cfg_load; in_data=5,-3,7 on consecutive cycles → out_data=5,-3,7, each 1 clk later, out_valid high 3 cycles.
- cfg_load D=3, then 6 samples 1..6 → cfg_busy high from the load until the 3rd sample; out_data=0,0,0,1,2,3; fill_count 1,2,3,3,3,3.
- D=MAX_DELAY=64, 130 ramp samples with random idle gaps → out_n = in_(n-64) after 64 zeros; gaps do not shift alignment.
- Samples 1..10 streaming at D=2; cfg_load D=4 coincident with sample 10 → that sample outputs 8 under the old D; one cycle in_ready=0; then 4 zeros, then new data.
- Assert rst mid-RUN → out_valid and out_data drop to 0 asynchronously; after release, IDLE pass-through.
- With DELAY_LINE_CFG_CHECK_EN: cfg_delay=100 (MAX_DELAY=64) → D clamped to 64, cfg_err=1; a legal load of 10 clears it; without the macro, D clamps the same way.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared types and helpers for the run-time programmable sample delay line.
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_PASS = 2'd1,
    SEL_RAM  = 2'd2
  } out_sel_e;

  localparam logic [63:0] ZERO_FILL = 64'd0;

  function automatic int delay_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/delay_line_ctrl_chk.sv
// Protocol checker for delay_line_ctrl, present only with DELAY_LINE_CFG_CHECK_EN.
`ifdef DELAY_LINE_CFG_CHECK_EN
module delay_line_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic in_valid,
  input logic in_ready
);

  a_no_valid_while_not_ready: assert property (
    @(posedge clk) disable iff (rst) !(in_valid && !in_ready)
  );

endmodule
`endif

// File: rtl/delay_ram.sv
// Simple dual-port sample buffer: registered, read-before-write read port.
module delay_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Read and write on the same edge; the read sees the entry before this write
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/delay_line_ctrl.sv
// Run-time programmable sample-counted delay line with fill/flush sequencing.
// Optional DELAY_LINE_CFG_CHECK_EN adds the sticky cfg_err port and a protocol checker.
module delay_line_ctrl
  import delay_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int MAX_DELAY = 64,
  localparam int DW        = delay_width(MAX_DELAY)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           cfg_delay,
  input  logic                    cfg_load,
  output logic                    cfg_busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_data,
  output logic [DW-1:0]           fill_count
`ifdef DELAY_LINE_CFG_CHECK_EN
  ,
  output logic                    cfg_err
`endif
);

  localparam int AW = addr_width(MAX_DELAY);

  state_e                   state_r, state_n;
  out_sel_e                 out_sel_r;
  logic [DW-1:0]            d_r;
  logic [DW-1:0]            d_load_s;
  logic [DW-1:0]            fill_count_r;
  logic [DW-1:0]            fill_inc_s;
  logic [AW-1:0]            wr_ptr_r;
  logic [AW-1:0]            wr_next_s;
  logic [AW-1:0]            rd_ptr_s;
  logic [DW:0]              wr_ext_s;
  logic [DW:0]              d_ext_s;
  logic [DW:0]              rd_ext_s;
  logic                     accept_s;
  logic                     ram_we_s;
  logic                     ram_re_s;
  logic [WIDTH-1:0]         ram_rdata_s;
  logic signed [WIDTH-1:0]  pass_data_r;
  logic signed [WIDTH-1:0]  out_data_s;
  logic                     out_valid_r;
  logic                     cfg_busy_r;
  logic                     in_ready_r;

  assign accept_s   = in_valid && in_ready_r;
  assign fill_inc_s = fill_count_r + {{(DW-1){1'b0}}, 1'b1};
  assign ram_we_s   = accept_s && ((state_r == FILL) || (state_r == RUN));
  assign ram_re_s   = accept_s && (state_r == RUN);

  // Config clamp and pointer arithmetic; the read address never underflows
  always_comb begin
    d_load_s  = cfg_delay;
    wr_next_s = wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
    wr_ext_s  = (DW+1)'(wr_ptr_r);
    d_ext_s   = {1'b0, d_r};
    rd_ext_s  = '0;
    if (cfg_delay > DW'(MAX_DELAY)) begin
      d_load_s = DW'(MAX_DELAY);
    end else begin
      d_load_s = cfg_delay;
    end
    if (wr_ptr_r == AW'(MAX_DELAY - 1)) begin
      wr_next_s = '0;
    end else begin
      wr_next_s = wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
    end
    if (wr_ext_s >= d_ext_s) begin
      rd_ext_s = wr_ext_s - d_ext_s;
    end else begin
      rd_ext_s = wr_ext_s + (DW+1)'(MAX_DELAY) - d_ext_s;
    end
    rd_ptr_s = AW'(rd_ext_s);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; a load preempts every state, including FLUSH itself
  always_comb begin
    state_n = state_r;
    if (cfg_load) begin
      state_n = FLUSH;
    end else begin
      case (state_r)
        IDLE: state_n = IDLE;
        FLUSH: begin
          if (d_r != '0) begin
            state_n = FILL;
          end else begin
            state_n = IDLE;
          end
        end
        FILL: begin
          if (accept_s && (fill_inc_s == d_r)) begin
            state_n = RUN;
          end else begin
            state_n = FILL;
          end
        end
        RUN:     state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  // Pointers, fill counter, active delay and output source registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_r          <= '0;
      wr_ptr_r     <= '0;
      fill_count_r <= '0;
      out_sel_r    <= SEL_ZERO;
      pass_data_r  <= '0;
      out_valid_r  <= 1'b0;
      cfg_busy_r   <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      out_valid_r <= accept_s;
      cfg_busy_r  <= (state_n == FLUSH) || (state_n == FILL);
      in_ready_r  <= (state_n != FLUSH);
      if (accept_s) begin
        case (state_r)
          IDLE: begin
            pass_data_r <= in_data;
            out_sel_r   <= SEL_PASS;
          end
          FILL: begin
            out_sel_r    <= SEL_ZERO;
            wr_ptr_r     <= wr_next_s;
            fill_count_r <= fill_inc_s;
          end
          RUN: begin
            out_sel_r <= SEL_RAM;
            wr_ptr_r  <= wr_next_s;
          end
          default: out_sel_r <= SEL_ZERO;
        endcase
      end
      if (state_r == FLUSH) begin
        wr_ptr_r     <= '0;
        fill_count_r <= '0;
      end
      if (cfg_load) begin
        d_r <= d_load_s;
      end
    end
  end

  delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (wr_ptr_r),
    .wdata (in_data),
    .re    (ram_re_s),
    .raddr (rd_ptr_s),
    .rdata (ram_rdata_s)
  );

  // Output mux over registered sources only; reset forces the zero source
  always_comb begin
    out_data_s = WIDTH'(ZERO_FILL);
    case (out_sel_r)
      SEL_PASS: out_data_s = pass_data_r;
      SEL_RAM:  out_data_s = ram_rdata_s;
      SEL_ZERO: out_data_s = WIDTH'(ZERO_FILL);
      default:  out_data_s = WIDTH'(ZERO_FILL);
    endcase
  end

  assign out_data   = out_data_s;
  assign out_valid  = out_valid_r;
  assign cfg_busy   = cfg_busy_r;
  assign in_ready   = in_ready_r;
  assign fill_count = fill_count_r;

`ifdef DELAY_LINE_CFG_CHECK_EN
  logic cfg_err_r;

  // Sticky out-of-range flag, cleared by the next legal load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err_r <= 1'b0;
    end else if (cfg_load) begin
      cfg_err_r <= (cfg_delay > DW'(MAX_DELAY));
    end else begin
      cfg_err_r <= cfg_err_r;
    end
  end

  assign cfg_err = cfg_err_r;

  delay_line_ctrl_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready_r)
  );
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed self-checking bench for delay_line_ctrl (default parameters).
module tb_delay_line_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic [6:0]         cfg_delay;
  logic               cfg_load;
  logic               cfg_busy;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic [6:0]         fill_count;
`ifdef DELAY_LINE_CFG_CHECK_EN
  logic               cfg_err;
`endif

  int tests = 0;
  int fails = 0;

  delay_line_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_delay  (cfg_delay),
    .cfg_load   (cfg_load),
    .cfg_busy   (cfg_busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .fill_count (fill_count)
`ifdef DELAY_LINE_CFG_CHECK_EN
    ,
    .cfg_err    (cfg_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic step(input logic v, input logic signed [15:0] d, input logic ld, input logic [6:0] cd);
    in_valid  = v;
    in_data   = d;
    cfg_load  = ld;
    cfg_delay = cd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  initial begin
    int gap;
    int exp_v;
    logic drop_v;
    rst       = 1'b1;
    cfg_delay = 7'd0;
    cfg_load  = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'sd0;
`ifdef DELAY_LINE_CFG_CHECK_EN
    drop_v = 1'b0;
`else
    drop_v = 1'b1;
`endif

    // Reset values
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cfg_busy", cfg_busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fill_count", fill_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // IDLE pass-through
    step(1'b1, 16'sd5, 1'b0, 7'd0);
    check("t1_v0", out_valid, 1);
    check("t1_d0", out_data, 5);
    step(1'b1, -16'sd3, 1'b0, 7'd0);
    check("t1_v1", out_valid, 1);
    check("t1_d1", out_data, -3);
    step(1'b1, 16'sd7, 1'b0, 7'd0);
    check("t1_v2", out_valid, 1);
    check("t1_d2", out_data, 7);
    step(1'b0, 16'sd0, 1'b0, 7'd0);
    check("t1_idle_v", out_valid, 0);

    // D=3 fill then run; a sample offered during FLUSH is dropped
    step(1'b0, 16'sd0, 1'b1, 7'd3);
    check("t2_flush_busy", cfg_busy, 1);
    check("t2_flush_ready", in_ready, 0);
    check("t2_flush_valid", out_valid, 0);
    step(drop_v, 16'sd99, 1'b0, 7'd0);
    check("t2_drop_valid", out_valid, 0);
    check("t2_fill_busy", cfg_busy, 1);
    check("t2_fill_ready", in_ready, 1);
    check("t2_fill_cnt0", fill_count, 0);
    for (int n = 1; n <= 6; n++) begin
      step(1'b1, 16'(n), 1'b0, 7'd0);
      check("t2_valid", out_valid, 1);
      check("t2_data", out_data, (n <= 3) ? 0 : n - 3);
      check("t2_fill", fill_count, (n <= 3) ? n : 3);
      check("t2_busy", cfg_busy, (n < 3) ? 1 : 0);
    end

    // D=MAX_DELAY with random idle gaps
    step(1'b0, 16'sd0, 1'b1, 7'd64);
    step(1'b0, 16'sd0, 1'b0, 7'd0);
    for (int n = 1; n <= 130; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 16'sd0, 1'b0, 7'd0);
        check("t3_gap_valid", out_valid, 0);
      end
      step(1'b1, 16'(n), 1'b0, 7'd0);
      exp_v = (n <= 64) ? 0 : n - 64;
      check("t3_valid", out_valid, 1);
      check("t3_data", out_data, exp_v);
    end
    check("t3_fill_sat", fill_count, 64);

    // D=2 stream, reload to D=4 coincident with sample 10
    step(1'b0, 16'sd0, 1'b1, 7'd2);
    step(1'b0, 16'sd0, 1'b0, 7'd0);
    for (int n = 1; n <= 9; n++) begin
      step(1'b1, 16'(n), 1'b0, 7'd0);
      check("t4_data", out_data, (n <= 2) ? 0 : n - 2);
    end
    step(1'b1, 16'sd10, 1'b1, 7'd4);
    check("t4_ld_valid", out_valid, 1);
    check("t4_ld_data", out_data, 8);
    check("t4_ld_ready", in_ready, 0);
    check("t4_ld_busy", cfg_busy, 1);
    step(1'b0, 16'sd0, 1'b0, 7'd0);
    check("t4_ready_back", in_ready, 1);
    for (int n = 11; n <= 16; n++) begin
      step(1'b1, 16'(n), 1'b0, 7'd0);
      check("t4_new_valid", out_valid, 1);
      check("t4_new_data", out_data, (n <= 14) ? 0 : n - 4);
    end

    // Asynchronous reset mid-RUN
    check("t5_pre_data", out_data, 12);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_fill", fill_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 16'sd42, 1'b0, 7'd0);
    check("t5_pass_valid", out_valid, 1);
    check("t5_pass_data", out_data, 42);
    check("t5_pass_busy", cfg_busy, 0);

    // Out-of-range request clamps to MAX_DELAY
    step(1'b0, 16'sd0, 1'b1, 7'd100);
`ifdef DELAY_LINE_CFG_CHECK_EN
    check("t6_err_set", cfg_err, 1);
`endif
    step(1'b0, 16'sd0, 1'b0, 7'd0);
    for (int n = 1; n <= 66; n++) begin
      step(1'b1, 16'(n + 100), 1'b0, 7'd0);
      check("t6_data", out_data, (n <= 64) ? 0 : n + 36);
    end
    check("t6_fill", fill_count, 64);
`ifdef DELAY_LINE_CFG_CHECK_EN
    step(1'b0, 16'sd0, 1'b1, 7'd10);
    check("t6_err_clr", cfg_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
